spi_sample_logger: RTL and testbench

Periodic acquisition and buffering stage directly downstream of `spi_master`. It issues `start` pulses to the master at a fixed sample interval and captures each 16-bit thermocouple frame when the transfer finishes. It decodes the 12-bit temperature and the open-circuit fault bit, tags each sample with a sequence number, and queues the result in a FIFO for the host-side reader.

---
 rtl/spi_log_pkg.sv | 36 +++
 rtl/spi_sample_logger_sync_fifo.sv | 56 +++++
 rtl/spi_sample_logger.sv | 156 +++++++++++++++
 tb/tb_spi_sample_logger.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_log_pkg.sv
// Shared definitions for spi_sample_logger: thermocouple frame fields,
// FIFO entry layout and acquisition FSM states.
package spi_log_pkg;

  localparam int FRAME_W   = 16;
  localparam int TEMP_MSB  = 14;
  localparam int TEMP_LSB  = 3;
  localparam int FAULT_BIT = 2;
  localparam int TEMP_W    = TEMP_MSB - TEMP_LSB + 1;
  localparam int SEQ_W     = 3;

  typedef struct packed {
    logic             fault;
    logic [SEQ_W-1:0] seq;
    logic [TEMP_W-1:0] temp;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAPTURE
  } state_t;

  function automatic entry_t make_entry(input logic [FRAME_W-1:0] frame,
                                        input logic [SEQ_W-1:0] seq);
    entry_t e;
    e.fault = frame[FAULT_BIT];
    e.seq   = seq;
    e.temp  = frame[TEMP_MSB:TEMP_LSB];
    return e;
  endfunction

endpackage

// File: rtl/spi_sample_logger_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Head reads as zero while empty; a pop on a full FIFO frees room for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_rd_en && (r_count != '0);
  assign w_push = i_wr_en && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/spi_sample_logger.sv
// Periodic thermocouple acquisition: starts spi_master, decodes frames, queues tagged samples.
// Optional SPI_LOG_DROP_FAULT_EN discards open-circuit frames instead of queueing them.
module spi_sample_logger
  import spi_log_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 25_000_000,
  parameter int FIFO_DEPTH    = 16,
  parameter int START_TIMEOUT = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  output logic                          o_spi_start,
  input  logic                          i_spi_busy,
  input  logic [15:0]                   i_spi_dout,
  input  logic                          i_rd_en,
  output logic [15:0]                   o_rd_data,
  output logic                          o_empty,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overflow,
  output logic                          o_timeout_err,
  input  logic                          i_clear_err
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int OW = $clog2(START_TIMEOUT + 1);

  state_t            r_state;
  state_t            w_next;
  logic [TW-1:0]     r_timer;
  logic              r_tick;
  logic              r_pending;
  logic [OW-1:0]     r_to_cnt;
  logic [15:0]       r_frame;
  logic [SEQ_W-1:0]  r_seq;
  logic              r_overflow;
  logic              r_timeout_err;
  logic              w_take_tick;
  logic              w_timeout;
  logic              w_push;
  logic              w_full;
  entry_t            w_entry;

  // Tick is registered so that start-to-start spacing is exactly SAMPLE_PERIOD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
      r_tick  <= 1'b0;
    end else if (!i_enable) begin
      r_timer <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= (r_timer == TW'(SAMPLE_PERIOD - 1));
      r_timer <= (r_timer == TW'(SAMPLE_PERIOD - 1)) ? '0 : r_timer + TW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_pending <= 1'b0;
    else if (!i_enable || w_take_tick)
      r_pending <= 1'b0;
    else if (r_tick && (r_state != S_WAIT_TICK) && (r_state != S_IDLE))
      r_pending <= 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // The START cycle counts as the first cycle waited for busy.
  always_comb begin
    w_next      = r_state;
    w_take_tick = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:      if (i_enable) w_next = S_START;
      S_WAIT_TICK: begin
        if (!i_enable) begin
          w_next = S_IDLE;
        end else if (r_tick || r_pending) begin
          w_next      = S_START;
          w_take_tick = 1'b1;
        end
      end
      S_START:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (i_spi_busy) begin
          w_next = S_WAIT_DONE;
        end else if (r_to_cnt == OW'(START_TIMEOUT - 2)) begin
          w_next    = S_WAIT_TICK;
          w_timeout = 1'b1;
        end
      end
      S_WAIT_DONE: if (!i_spi_busy) w_next = S_CAPTURE;
      S_CAPTURE:   w_next = S_WAIT_TICK;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
      r_frame  <= '0;
      r_seq    <= '0;
    end else begin
      r_to_cnt <= (r_state == S_WAIT_BUSY) ? r_to_cnt + OW'(1) : '0;
      if ((r_state == S_WAIT_DONE) && !i_spi_busy) r_frame <= i_spi_dout;
      if (w_push) r_seq <= r_seq + SEQ_W'(1);
    end
  end

  assign w_entry = make_entry(r_frame, r_seq);

`ifdef SPI_LOG_DROP_FAULT_EN
  assign w_push = (r_state == S_CAPTURE) && !w_entry.fault;
`else
  assign w_push = (r_state == S_CAPTURE);
`endif

  // A new error outranks a coincident clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_push && w_full && !i_rd_en) r_overflow <= 1'b1;
      else if (i_clear_err)             r_overflow <= 1'b0;
      if (w_timeout)                    r_timeout_err <= 1'b1;
      else if (i_clear_err)             r_timeout_err <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_push),
    .i_wr_data (w_entry),
    .i_rd_en   (i_rd_en),
    .o_rd_data (o_rd_data),
    .o_empty   (o_empty),
    .o_full    (w_full),
    .o_count   (o_count)
  );

  assign o_full        = w_full;
  assign o_spi_start   = (r_state == S_START);
  assign o_overflow    = r_overflow;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_spi_sample_logger.sv
// Scoreboard bench for spi_sample_logger with a behavioural spi_master (busy 40 cycles).
module tb_spi_sample_logger;

  localparam int P  = 1000;
  localparam int D  = 4;
  localparam int TO = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear_err = 1'b0;
  logic          rd_man = 1'b0;
  logic          rd_auto = 1'b0;
  logic          auto_rd = 1'b0;
  logic          no_busy = 1'b0;
  logic          busy;
  logic          w_rd_en;
  logic [15:0]   dout;
  logic [15:0]   rd_data;
  logic          spi_start, empty, full, overflow, timeout_err;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int bcnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] frame_q[$];
  int          start_q[$];

  always #5 clk = ~clk;

  assign w_rd_en = rd_man | rd_auto;
  assign busy    = (bcnt > 0);

  spi_sample_logger #(
    .SAMPLE_PERIOD (P),
    .FIFO_DEPTH    (D),
    .START_TIMEOUT (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .o_spi_start   (spi_start),
    .i_spi_busy    (busy),
    .i_spi_dout    (dout),
    .i_rd_en       (w_rd_en),
    .o_rd_data     (rd_data),
    .o_empty       (empty),
    .o_full        (full),
    .o_count       (count),
    .o_overflow    (overflow),
    .o_timeout_err (timeout_err),
    .i_clear_err   (clear_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // busy rises one cycle after start and stays high for 40 cycles
  always @(posedge clk) begin
    if (!rst_n) begin
      bcnt <= 0;
      dout <= 16'h0;
    end else if (spi_start && !no_busy) begin
      bcnt <= 40;
      if (frame_q.size() > 0) dout <= frame_q.pop_front();
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: logs starts and checks every popped head against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && spi_start) start_q.push_back(cyc);
      if (rst_n && w_rd_en && !empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h with nothing expected", rd_data);
        end else begin
          chk("pop_entry", {16'h0, rd_data}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      rd_auto = auto_rd && !empty;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    auto_rd = 1'b0;
    rd_man = 1'b0;
    clear_err = 1'b0;
    no_busy = 1'b0;
    exp_q.delete();
    frame_q.delete();
    start_q.delete();
    step(3);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (start_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    chk("start_count", start_q.size(), n);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      step(1);
      k++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  logic [15:0] tbl_frame [9];
  logic [15:0] tbl_exp   [9];
  int e, s, at, k;
  logic [15:0] head;
  logic [3:0]  exp_cnt;

  initial begin
    tbl_frame = '{16'h0C80, 16'h7FF8, 16'h8003, 16'h1238, 16'h0FA0,
                  16'h4008, 16'h0001, 16'h3E80, 16'h0648};
    tbl_exp   = '{16'h0190, 16'h1FFF, 16'h2000, 16'h3247, 16'h41F4,
                  16'h5801, 16'h6000, 16'h77D0, 16'h00C9};

    // reset state
    do_reset();
    chk("rst_spi_start", spi_start, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout_err, 0);

    // single sample, then periodicity and seq wrap
    frame_q.push_back(tbl_frame[0]);
    exp_q.push_back(tbl_exp[0]);
    e = cyc;
    enable = 1'b1;
    wait_starts(1, 10);
    chk("first_start_cycle", start_q[0], e + 1);
    k = 0;
    while (empty && k < 100) begin step(1); k++; end
    at = cyc;
    chk("capture_latency", at - start_q[0], 43);
    chk("single_count", count, 1);
    for (int i = 1; i < 9; i++) begin
      frame_q.push_back(tbl_frame[i]);
      exp_q.push_back(tbl_exp[i]);
    end
    auto_rd = 1'b1;
    wait_starts(9, 9500);
    for (int i = 1; i < 9; i++) chk("start_spacing", start_q[i] - start_q[i-1], P);
    step(60);
    enable = 1'b0;
    wait_drain(20);
    step(1100);
    chk("no_start_when_disabled", start_q.size(), 9);

    // overflow: four fit, fifth dropped, sixth pushes alongside a pop
    do_reset();
    for (int i = 1; i <= 6; i++) frame_q.push_back(16'(i * 8));
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h1002);
    exp_q.push_back(16'h2003);
    exp_q.push_back(16'h3004);
    exp_q.push_back(16'h5006);
    enable = 1'b1;
    wait_starts(5, 4200);
    step(60);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 4);
    chk("ovf_flag", overflow, 1);
    head = rd_data;
    chk("ovf_head_seq", head[14:12], 0);
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    chk("ovf_cleared", overflow, 0);
    wait_starts(6, 1100);
    k = 0;
    while (busy && k < 100) begin step(1); k++; end
    step(1);
    rd_man = 1'b1;
    step(1);
    rd_man = 1'b0;
    chk("pushpop_count", count, 4);
    chk("pushpop_overflow", overflow, 0);
    chk("pushpop_full", full, 1);
    enable = 1'b0;
    auto_rd = 1'b1;
    wait_drain(40);

    // fault frame followed by a normal frame
    do_reset();
    frame_q.push_back(16'h0004);
    frame_q.push_back(16'h0008);
`ifdef SPI_LOG_DROP_FAULT_EN
    exp_q.push_back(16'h0001);
    exp_cnt = 4'd0;
`else
    exp_q.push_back(16'h8000);
    exp_q.push_back(16'h1001);
    exp_cnt = 4'd1;
`endif
    enable = 1'b1;
    wait_starts(1, 10);
    step(60);
    chk("fault_count", count, exp_cnt);
    auto_rd = 1'b1;
    wait_starts(2, 1100);
    step(60);
    enable = 1'b0;
    wait_drain(20);

    // timeout: busy never rises
    do_reset();
    no_busy = 1'b1;
    enable = 1'b1;
    wait_starts(1, 10);
    s = start_q[0];
    k = 0;
    while (cyc < s + 7 && k < 20) begin step(1); k++; end
    chk("timeout_early", timeout_err, 0);
    step(1);
    chk("timeout_set", timeout_err, 1);
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    chk("timeout_cleared", timeout_err, 0);
    wait_starts(2, 1100);
    chk("timeout_spacing", start_q[1] - start_q[0], P);
    k = 0;
    while (cyc < start_q[1] + 7 && k < 20) begin step(1); k++; end
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    chk("error_beats_clear", timeout_err, 1);
    chk("timeout_fifo_empty", empty, 1);
    enable = 1'b0;
    no_busy = 1'b0;
    step(2);

    // reset in the middle of a transaction
    do_reset();
    frame_q.push_back(16'h0008);
    frame_q.push_back(16'h0010);
    frame_q.push_back(16'h0018);
    enable = 1'b1;
    wait_starts(3, 2200);
    step(10);
    chk("pre_reset_count", count, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_empty", empty, 1);
    chk("midrst_count", count, 0);
    chk("midrst_start", spi_start, 0);
    exp_q.delete();
    frame_q.delete();
    start_q.delete();
    frame_q.push_back(16'h0020);
    exp_q.push_back(16'h0004);
    step(3);
    rst_n = 1'b1;
    auto_rd = 1'b1;
    wait_starts(1, 10);
    step(60);
    enable = 1'b0;
    wait_drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
